// File: rtl/pixel_unpacker.sv
// AXI4-Stream sink that unpacks 24-bit RGB pixels (4 pixels per 3 beats) into a
// ready/valid pixel stream, tagging each pixel with x/y, SOF, EOL and checking framing.
module pixel_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        in_stream_aclk,
  input  logic        periph_resetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  input  logic        err_clear,
  output logic        err_sync,
  output logic        err_eol,
  output logic [15:0] frame_count
);

  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [9:0] X_PEN  = 10'(X_SIZE - 2);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  typedef enum logic [1:0] {PH0, PH1, PH2} phase_e;

  // Handshake: a beat transfers when tvalid && tready; a pixel transfers when
  // pix_valid && pix_ready; pix_valid and its data hold stable until pix_ready.
  phase_e      phase_q, phase_d, eff_phase;
  logic [15:0] residual_q, residual_d;
  logic [23:0] pending_q, pending_d;
  logic        pending_valid_q, pending_valid_d;
  logic [9:0]  x_q, x_d, lx;
  logic [8:0]  y_q, y_d, ly;
  logic [23:0] pix_data_q, pix_data_d, new_pix;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [8:0]  pix_y_q, pix_y_d;
  logic        pix_sof_q, pix_sof_d;
  logic        pix_eol_q, pix_eol_d;
  logic        pix_valid_q, pix_valid_d;
  logic        err_sync_q, err_sync_d;
  logic        err_eol_q, err_eol_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        load_ok, beat_acc, do_load, sync_err, eol_err, exp_last;
  logic        unused_tkeep;

  assign unused_tkeep = ^in_stream_tkeep;

  always_comb begin
    phase_d         = phase_q;
    residual_d      = residual_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    x_d             = x_q;
    y_d             = y_q;
    pix_data_d      = pix_data_q;
    pix_x_d         = pix_x_q;
    pix_y_d         = pix_y_q;
    pix_sof_d       = pix_sof_q;
    pix_eol_d       = pix_eol_q;
    pix_valid_d     = pix_valid_q;
    frame_count_d   = frame_count_q;
    new_pix         = 24'h0;
    do_load         = 1'b0;
    sync_err        = 1'b0;
    eol_err         = 1'b0;
    exp_last        = 1'b0;

    load_ok          = !pix_valid_q || pix_ready;
    in_stream_tready = periph_resetn && load_ok && !pending_valid_q;
    beat_acc         = in_stream_tvalid && in_stream_tready;

    // A SOF beat restarts unpacking and counting at phase 0, pixel (0,0).
    eff_phase = (beat_acc && in_stream_tuser) ? PH0 : phase_q;
    lx        = (beat_acc && in_stream_tuser) ? 10'd0 : x_q;
    ly        = (beat_acc && in_stream_tuser) ? 9'd0 : y_q;

    if (beat_acc) begin
      do_load = 1'b1;
      case (eff_phase)
        PH0: begin
          new_pix    = in_stream_tdata[23:0];
          residual_d = {8'h00, in_stream_tdata[31:24]};
          phase_d    = PH1;
        end
        PH1: begin
          new_pix    = {in_stream_tdata[15:0], residual_q[7:0]};
          residual_d = in_stream_tdata[31:16];
          phase_d    = PH2;
        end
        default: begin
          new_pix         = {in_stream_tdata[7:0], residual_q};
          pending_d       = in_stream_tdata[31:8];
          pending_valid_d = 1'b1;
          phase_d         = PH0;
        end
      endcase
      sync_err = in_stream_tuser && (phase_q != PH0 || x_q != 10'd0 || y_q != 9'd0);
      // tlast belongs on the phase-2 beat whose trailing pixel closes the line.
      exp_last = (eff_phase == PH2) && (lx == X_PEN);
      eol_err  = (in_stream_tlast != exp_last);
    end else if (pending_valid_q && load_ok) begin
      do_load         = 1'b1;
      new_pix         = pending_q;
      pending_valid_d = 1'b0;
    end

    if (do_load) begin
      pix_valid_d = 1'b1;
      pix_data_d  = new_pix;
      pix_x_d     = lx;
      pix_y_d     = ly;
      pix_sof_d   = (lx == 10'd0) && (ly == 9'd0);
      pix_eol_d   = (lx == X_LAST);
      if (lx == X_LAST) begin
        x_d = 10'd0;
        y_d = (ly == Y_LAST) ? 9'd0 : ly + 9'd1;
      end else begin
        x_d = lx + 10'd1;
        y_d = ly;
      end
    end else if (pix_ready) begin
      pix_valid_d = 1'b0;
    end

    if (pix_valid_q && pix_ready && pix_x_q == X_LAST && pix_y_q == Y_LAST) begin
      frame_count_d = frame_count_q + 16'd1;
    end

    err_sync_d = (err_sync_q && !err_clear) || sync_err;
    err_eol_d  = (err_eol_q && !err_clear) || eol_err;
  end

  always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      phase_q         <= PH0;
      residual_q      <= 16'h0;
      pending_q       <= 24'h0;
      pending_valid_q <= 1'b0;
      x_q             <= 10'd0;
      y_q             <= 9'd0;
      pix_data_q      <= 24'h0;
      pix_x_q         <= 10'd0;
      pix_y_q         <= 9'd0;
      pix_sof_q       <= 1'b0;
      pix_eol_q       <= 1'b0;
      pix_valid_q     <= 1'b0;
      err_sync_q      <= 1'b0;
      err_eol_q       <= 1'b0;
      frame_count_q   <= 16'd0;
    end else begin
      phase_q         <= phase_d;
      residual_q      <= residual_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      x_q             <= x_d;
      y_q             <= y_d;
      pix_data_q      <= pix_data_d;
      pix_x_q         <= pix_x_d;
      pix_y_q         <= pix_y_d;
      pix_sof_q       <= pix_sof_d;
      pix_eol_q       <= pix_eol_d;
      pix_valid_q     <= pix_valid_d;
      err_sync_q      <= err_sync_d;
      err_eol_q       <= err_eol_d;
      frame_count_q   <= frame_count_d;
    end
  end

  assign pix_r       = pix_data_q[23:16];
  assign pix_g       = pix_data_q[15:8];
  assign pix_b       = pix_data_q[7:0];
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_sof     = pix_sof_q;
  assign pix_eol     = pix_eol_q;
  assign pix_valid   = pix_valid_q;
  assign err_sync    = err_sync_q;
  assign err_eol     = err_eol_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Bench for pixel_unpacker: byte-queue reference model, per-cycle compare process,
// directed frames covering stalls, tlast/tuser errors and mid-line reset.
module tb_pixel_unpacker;
  localparam int XS = 8;
  localparam int YS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_sof, pix_eol, pix_valid, pix_ready;
  logic        err_clear, err_sync, err_eol;
  logic [15:0] frame_count;

  pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
    .in_stream_aclk(clk), .periph_resetn(rst_n),
    .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tlast(tlast),
    .in_stream_tuser(tuser), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .err_clear(err_clear), .err_sync(err_sync), .err_eol(err_eol),
    .frame_count(frame_count)
  );

  // Clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic check_en = 1'b0;
  int ready_mode = 0;

  // Expected pixel: {rgb[23:0], x[9:0], y[8:0], sof, eol}
  logic [44:0] exp_q[$];
  logic [23:0] seen[$];
  logic [7:0]  m_bytes[$];
  int   m_x, m_y, exp_frames;
  logic exp_err_sync, exp_err_eol;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_bytes.delete();
    m_x = 0;
    m_y = 0;
    exp_frames = 0;
    exp_err_sync = 1'b0;
    exp_err_eol = 1'b0;
  endtask

  // Bytes arrive little-endian; every 3 bytes form one {r,g,b} pixel.
  task automatic model_beat(input logic [31:0] d, input logic u, input logic l);
    logic completes;
    logic [7:0] b0, b1, b2;
    completes = 1'b0;
    if (u) begin
      if (m_bytes.size() != 0 || m_x != 0 || m_y != 0) exp_err_sync = 1'b1;
      m_bytes.delete();
      m_x = 0;
      m_y = 0;
    end
    for (int j = 0; j < 4; j++) m_bytes.push_back(d[8*j +: 8]);
    while (m_bytes.size() >= 3) begin
      b0 = m_bytes.pop_front();
      b1 = m_bytes.pop_front();
      b2 = m_bytes.pop_front();
      exp_q.push_back({b2, b1, b0, 10'(m_x), 9'(m_y),
                       1'((m_x == 0) && (m_y == 0)), 1'(m_x == XS - 1)});
      if (m_x == XS - 1) begin
        completes = 1'b1;
        m_x = 0;
        m_y = (m_y + 1) % YS;
      end else begin
        m_x++;
      end
    end
    if (l != completes) exp_err_eol = 1'b1;
  endtask

  function automatic logic [31:0] beat_data(input int i);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'((17 * (4 * i + j + 1)) & 255);
    return w;
  endfunction

  // Driver tasks: entered and left just after a rising edge.
  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    logic acc;
    acc = 1'b0;
    tdata = d;
    tuser = u;
    tlast = l;
    tvalid = 1'b1;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk);
    end
    if (acc) model_beat(d, u, l);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_accept_timeout: tready never high for beat %0h", d);
    end
    #1;
    tvalid = 1'b0;
    tuser = 1'b0;
    tlast = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input int last_a);
    for (int i = from; i <= to; i++)
      send_beat(beat_data(i), 1'(i == 0), 1'((i == last_a) || (i == 11)));
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0);
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d pixels still expected", exp_q.size());
    end
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(posedge clk);
    exp_err_sync = 1'b0;
    exp_err_eol = 1'b0;
    #1;
    err_clear = 1'b0;
  endtask

  // Downstream ready pattern
  initial begin
    int tog;
    tog = 0;
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: begin
          pix_ready = ((tog % 4) == 0) || ((tog % 4) == 3);
          tog++;
        end
        default: pix_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard compare, sampled on the falling edge
  initial begin
    logic hold;
    logic [44:0] held, act, e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (check_en) begin
        act = {pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol};
        chk("frame_count", frame_count, exp_frames);
        chk("err_sync", err_sync, exp_err_sync);
        chk("err_eol", err_eol, exp_err_eol);
        if (hold) begin
          chk("hold_valid", pix_valid, 1);
          chk("hold_data", act, held);
        end
        if (pix_valid && !pix_ready) chk("stall_tready", tready, 0);
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_pixel: got %0h with nothing expected", act);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", act, e);
            seen.push_back(act[44:21]);
            if (e[20:11] == 10'(XS - 1) && e[10:2] == 9'(YS - 1)) exp_frames++;
          end
        end
        hold = pix_valid && !pix_ready;
        held = act;
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0;
    tvalid = 1'b0;
    tdata = '0;
    tkeep = 4'hF;
    tuser = 1'b0;
    tlast = 1'b0;
    err_clear = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", tready, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_frame", frame_count, 0);
    chk("rst_err", {err_sync, err_eol}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_after_rst", tready, 1);
    check_en = 1'b1;

    // Clean frame, ready always high
    send_range(0, 11, 5);
    drain();
    chk("frame1_pix_count", seen.size(), 16);
    chk("pix0", seen[0], 24'h332211);
    chk("pix1", seen[1], 24'h665544);
    chk("pix2", seen[2], 24'h998877);
    chk("pix3", seen[3], 24'hCCBBAA);
    chk("frame1_count", frame_count, 1);
    chk("frame1_err", {err_sync, err_eol}, 0);

    // Same frame with downstream stalls
    ready_mode = 1;
    send_range(0, 11, 5);
    drain();
    ready_mode = 0;
    chk("frame2_pix_count", seen.size(), 32);
    chk("frame2_count", frame_count, 2);

    // Early tlast, then missing tlast
    send_range(0, 2, 2);
    chk("eol_early", err_eol, 1);
    clear_errs();
    chk("eol_clear1", err_eol, 0);
    send_range(3, 5, 2);
    chk("eol_missing", err_eol, 1);
    clear_errs();
    chk("eol_clear2", err_eol, 0);
    send_range(6, 11, 2);
    drain();
    chk("frame3_count", frame_count, 3);
    chk("frame3_err_eol", err_eol, 0);

    // SOF resync on a phase-1 beat
    send_range(0, 3, -1);
    drain();
    base = seen.size();
    send_beat(beat_data(4), 1'b1, 1'b0);
    send_range(5, 6, -1);
    drain();
    chk("sync_err", err_sync, 1);
    chk("sync_pix_count", seen.size() - base, 4);
    chk("sync_pix0", seen[base], 24'h433221);

    // Asynchronous reset with a stalled output pixel
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_beat(beat_data(7), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", pix_valid, 1);
    chk("pre_rst_frame", frame_count, 3);
    check_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", pix_valid, 0);
    chk("mid_rst_err", {err_sync, err_eol}, 0);
    chk("mid_rst_frame", frame_count, 0);
    chk("mid_rst_tready", tready, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    chk("tready_after_rst2", tready, 1);
    check_en = 1'b1;
    base = seen.size();
    send_range(0, 11, 5);
    drain();
    chk("post_rst_pix0", seen[base], 24'h332211);
    chk("post_rst_frame", frame_count, 1);
    chk("post_rst_err", {err_sync, err_eol}, 0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
